// File: rtl/move_request_ctrl_pkg.sv
// move_request_ctrl_pkg: direction codes, FSM state encoding and the
// lowest-set-bit helper shared by the move request controller and the
// game-state block.
package move_request_ctrl_pkg;

  // Direction code equals the switch bit index.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOLD_DELAY = 2'd1,
    ST_REPEAT     = 2'd2
  } state_e;

  // Lowest set index wins when several switches rise in the same cycle.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] r;
    r = DIR_UP;
    if (v[0])      r = DIR_UP;
    else if (v[1]) r = DIR_DOWN;
    else if (v[2]) r = DIR_LEFT;
    else if (v[3]) r = DIR_RIGHT;
    return r;
  endfunction

endpackage

// File: rtl/move_request_ctrl_timer.sv
// move_repeat_timer: auto-repeat interval counter.
//   i_Clk, i_Rst_L : clock, synchronous active-low reset
//   i_Clr          : force count to 0 (has priority over i_En)
//   i_En           : advance the count; wraps to 0 on terminal count
//   i_Sel_Repeat   : 0 selects CLKS_INITIAL limit, 1 selects CLKS_REPEAT
//   o_Tc           : count equals the selected limit minus one
module move_repeat_timer #(
  parameter int CLKS_INITIAL = 12_500_000,
  parameter int CLKS_REPEAT  = 5_000_000,
  parameter int CNT_W        = 24
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Clr,
  input  logic i_En,
  input  logic i_Sel_Repeat,
  output logic o_Tc
);

  localparam logic [CNT_W-1:0] LIM_INIT = CNT_W'(CLKS_INITIAL - 1);
  localparam logic [CNT_W-1:0] LIM_REP  = CNT_W'(CLKS_REPEAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_Tc = (cnt_q == (i_Sel_Repeat ? LIM_REP : LIM_INIT));

  // Count returns to 0 on terminal count so it never passes the active limit.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr)     cnt_d = '0;
    else if (i_En) cnt_d = o_Tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/move_request_ctrl.sv
// move_request_ctrl: turns debounced switch levels into directional move
// requests with press-to-move and hold-to-auto-repeat, presented on a
// valid/ready handshake.
//   i_Clk, i_Rst_L : clock, synchronous active-low reset
//   i_Switches[3:0]: debounced levels (0 up, 1 down, 2 left, 3 right)
//   i_Enable       : game running; low cancels state and pending request
//   i_Move_Ready   : consumer accepts the pending request this cycle
//   o_Move_Valid   : request pending
//   o_Move_Dir[1:0]: direction of the pending request
//   o_Drop_Count   : saturating count of requests lost to a busy consumer
module move_request_ctrl
  import move_request_ctrl_pkg::*;
#(
  parameter int CLKS_INITIAL = 12_500_000,
  parameter int CLKS_REPEAT  = 5_000_000,
  parameter int CNT_W        = 24
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Switches,
  input  logic       i_Enable,
  input  logic       i_Move_Ready,
  output logic       o_Move_Valid,
  output logic [1:0] o_Move_Dir,
  output logic [7:0] o_Drop_Count
);

  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] prev_q;
  logic       valid_q, valid_d;
  logic [1:0] out_dir_q, out_dir_d;
  logic [7:0] drop_q, drop_d;

  logic [3:0] rise;
  logic       gen, tmr_clr, tmr_en, tmr_tc;

  assign rise = i_Switches & ~prev_q;

  move_repeat_timer #(
    .CLKS_INITIAL(CLKS_INITIAL),
    .CLKS_REPEAT (CLKS_REPEAT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Clr       (tmr_clr),
    .i_En        (tmr_en),
    .i_Sel_Repeat(state_q == ST_REPEAT),
    .o_Tc        (tmr_tc)
  );

  // Next state / request generation
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    gen     = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    if (!i_Enable) begin
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tmr_clr = 1'b1;
          if (rise != 4'b0) begin
            dir_d   = lowest_idx(rise);
            gen     = 1'b1;
            state_d = ST_HOLD_DELAY;
          end
        end
        ST_HOLD_DELAY, ST_REPEAT: begin
          if (!i_Switches[dir_q]) begin
            state_d = ST_IDLE;
            tmr_clr = 1'b1;
          end else if (tmr_tc) begin
            gen     = 1'b1;
            tmr_clr = 1'b1;
            state_d = ST_REPEAT;
          end else begin
            tmr_en  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // Handshake register and drop counter. A new request while the old one is
  // still unaccepted is discarded; accept plus new request reloads directly.
  always_comb begin
    valid_d   = valid_q;
    out_dir_d = out_dir_q;
    drop_d    = drop_q;
    if (!i_Enable) begin
      valid_d = 1'b0;
    end else if (gen) begin
      if (valid_q && !i_Move_Ready) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        valid_d   = 1'b1;
        out_dir_d = dir_d;
      end
    end else if (valid_q && i_Move_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      prev_q    <= 4'b1111;  // levels held through reset must not look like presses
      valid_q   <= 1'b0;
      out_dir_q <= DIR_UP;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      prev_q    <= i_Switches;
      valid_q   <= valid_d;
      out_dir_q <= out_dir_d;
      drop_q    <= drop_d;
    end
  end

  assign o_Move_Valid = valid_q;
  assign o_Move_Dir   = out_dir_q;
  assign o_Drop_Count = drop_q;

endmodule

// File: tb/tb_move_request_ctrl.sv
module tb_move_request_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic [3:0] i_Switches;
  logic       i_Enable;
  logic       i_Move_Ready;
  logic       o_Move_Valid;
  logic [1:0] o_Move_Dir;
  logic [7:0] o_Drop_Count;

  int checks = 0;
  int errors = 0;

  always #5 i_Clk = ~i_Clk;

  move_request_ctrl #(.CLKS_INITIAL(8), .CLKS_REPEAT(4), .CNT_W(24)) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Switches  (i_Switches),
    .i_Enable    (i_Enable),
    .i_Move_Ready(i_Move_Ready),
    .o_Move_Valid(o_Move_Valid),
    .o_Move_Dir  (o_Move_Dir),
    .o_Drop_Count(o_Drop_Count)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] sw;
    logic       en;
    logic       rdy;
    logic       ev;
    logic [1:0] ed;
    logic [7:0] edrop;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  // Drive inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic rst_n, input logic [3:0] sw, input logic en, input logic rdy);
    i_Rst_L = rst_n; i_Switches = sw; i_Enable = en; i_Move_Ready = rdy;
    @(posedge i_Clk);
    #1;
  endtask

  // Direction is only meaningful while valid, or right after reset.
  task automatic check(input string name, input logic ev, input logic [1:0] ed,
                       input logic chk_dir, input logic [7:0] edrop);
    checks++;
    if (o_Move_Valid !== ev || (chk_dir && o_Move_Dir !== ed) || o_Drop_Count !== edrop) begin
      errors++;
      $display("FAIL %s: got valid=%0b dir=%0d drop=%0d, want valid=%0b dir=%0d drop=%0d",
               name, o_Move_Valid, o_Move_Dir, o_Drop_Count, ev, ed, edrop);
    end
  endtask

  function automatic vec_t mk(logic r, logic [3:0] s, logic e, logic y,
                              logic v, logic [1:0] d);
    vec_t t;
    t.rst_n = r; t.sw = s; t.en = e; t.rdy = y; t.ev = v; t.ed = d; t.edrop = 8'd0;
    return t;
  endfunction

  initial begin
    int exp_drop;
    logic ev;
    // reset with up held, then release: no request
    tbl[0]  = mk(0, 4'b0001, 1, 1, 0, 2'd0);
    tbl[1]  = mk(1, 4'b0001, 1, 1, 0, 2'd0);
    tbl[2]  = mk(1, 4'b0001, 1, 1, 0, 2'd0);
    tbl[3]  = mk(1, 4'b0000, 1, 1, 0, 2'd0);
    // tap left for 3 cycles: single request, one cycle
    tbl[4]  = mk(1, 4'b0100, 1, 1, 1, 2'd2);
    tbl[5]  = mk(1, 4'b0100, 1, 1, 0, 2'd0);
    tbl[6]  = mk(1, 4'b0100, 1, 1, 0, 2'd0);
    tbl[7]  = mk(1, 4'b0000, 1, 1, 0, 2'd0);
    tbl[8]  = mk(1, 4'b0000, 1, 1, 0, 2'd0);
    // right+down rise together: down wins; right held alone stays silent
    tbl[9]  = mk(1, 4'b1010, 1, 1, 1, 2'd1);
    tbl[10] = mk(1, 4'b1000, 1, 1, 0, 2'd0);
    tbl[11] = mk(1, 4'b1000, 1, 1, 0, 2'd0);
    tbl[12] = mk(1, 4'b1000, 1, 1, 0, 2'd0);
    tbl[13] = mk(1, 4'b1000, 1, 1, 0, 2'd0);
    tbl[14] = mk(1, 4'b0000, 1, 1, 0, 2'd0);
    tbl[15] = mk(1, 4'b1000, 1, 1, 1, 2'd3);
    tbl[16] = mk(1, 4'b0000, 1, 1, 0, 2'd0);
    // pending request cancelled by enable low, not counted, not refired
    tbl[17] = mk(1, 4'b0000, 1, 1, 0, 2'd0);
    tbl[18] = mk(1, 4'b0001, 1, 0, 1, 2'd0);
    tbl[19] = mk(1, 4'b0001, 0, 0, 0, 2'd0);
    tbl[20] = mk(1, 4'b0001, 1, 0, 0, 2'd0);
    tbl[21] = mk(1, 4'b0000, 1, 1, 0, 2'd0);
    // press while disabled is lost
    tbl[22] = mk(1, 4'b0100, 0, 1, 0, 2'd0);
    tbl[23] = mk(1, 4'b0100, 1, 1, 0, 2'd0);
    tbl[24] = mk(1, 4'b0000, 1, 1, 0, 2'd0);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst_n, tbl[i].sw, tbl[i].en, tbl[i].rdy);
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed,
            tbl[i].ev || !tbl[i].rst_n, tbl[i].edrop);
    end

    // Hold up 30 cycles: requests after steps 0,8,12,...,28, one cycle each.
    for (int k = 0; k < 30; k++) begin
      step(1, 4'b0001, 1, 1);
      ev = (k == 0) || (k >= 8 && (k % 4) == 0);
      check($sformatf("hold_t%0d", k + 1), ev, 2'd0, ev, 8'd0);
    end
    for (int k = 0; k < 12; k++) begin
      step(1, 4'b0000, 1, 1);
      check($sformatf("hold_rel%0d", k), 1'b0, 2'd0, 1'b0, 8'd0);
    end

    // Backpressure on down for 20 cycles: valid held, repeats dropped.
    exp_drop = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 4'b0010, 1, 0);
      if (k == 8 || k == 12 || k == 16) exp_drop++;
      check($sformatf("bp_t%0d", k + 1), 1'b1, 2'd1, 1'b1, 8'(exp_drop));
    end
    step(1, 4'b0000, 1, 1);
    check("bp_accept", 1'b0, 2'd0, 1'b0, 8'd3);
    step(1, 4'b0000, 1, 1);
    check("bp_idle", 1'b0, 2'd0, 1'b0, 8'd3);

    // Long backpressured hold on right: drop count saturates at 255.
    exp_drop = 3;
    for (int k = 0; k < 1100; k++) begin
      step(1, 4'b1000, 1, 0);
      if (k >= 8 && (k % 4) == 0 && exp_drop < 255) exp_drop++;
    end
    check("drop_sat", 1'b1, 2'd3, 1'b1, 8'(exp_drop));
    for (int k = 0; k < 8; k++) step(1, 4'b1000, 1, 0);
    check("drop_sat_hold", 1'b1, 2'd3, 1'b1, 8'd255);

    // Reset while in REPEAT with right held; no fire after release of reset.
    step(0, 4'b1000, 1, 1);
    check("rst_mid_repeat", 1'b0, 2'd0, 1'b1, 8'd0);
    for (int k = 0; k < 12; k++) begin
      step(1, 4'b1000, 1, 1);
      check($sformatf("post_rst%0d", k), 1'b0, 2'd0, 1'b0, 8'd0);
    end
    // fresh press after release works again
    step(1, 4'b0000, 1, 1);
    step(1, 4'b1000, 1, 1);
    check("post_rst_press", 1'b1, 2'd3, 1'b1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
